// File: rtl/puf_pkg.sv
// Shared definitions for the PUF evaluation controller: FSM encoding and
// default measurement timing.
package puf_pkg;

    localparam int DEF_WINDOW_CYCLES = 200;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_NBITS         = 8;
    localparam int CLEAR_CYCLES      = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } puf_state_e;

endpackage

// File: rtl/puf_timer.sv
// Loadable 16-bit down-counter; done is high on the last cycle of a loaded
// interval, so a load of N yields exactly N cycles before done is consumed.
module puf_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        done
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 16'd1);

endmodule

// File: rtl/puf_eval_ctrl.sv
// Ring-oscillator PUF evaluation sequencer: per response bit it clears the
// bank counters, runs the oscillators, lets them settle and compares counts.
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int NBITS         = DEF_NBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       challenge_base,
    input  logic [7:0]       count_a,
    input  logic [7:0]       count_b,
    output logic             ro_en,
    output logic             ro_clr,
    output logic [4:0]       challenge_out,
    output logic [NBITS-1:0] resp,
    output logic [NBITS-1:0] resp_tie,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam int          IDX_W     = $clog2(NBITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);
    localparam logic [15:0] CLR_LOAD  = 16'(CLEAR_CYCLES);
    localparam logic [15:0] WIN_LOAD  = 16'(WINDOW_CYCLES);
    localparam logic [15:0] SET_LOAD  = 16'(SETTLE_CYCLES);

    puf_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [4:0]       chal_q;
    logic [NBITS-1:0] resp_q;
    logic [NBITS-1:0] tie_q;
    logic             ro_en_q;
    logic             ro_clr_q;
    logic             valid_q;
    logic             busy_q;

    logic             tmr_load;
    logic [15:0]      tmr_val;
    logic             tmr_done;

    // The timer is reloaded on the same edge the FSM enters a timed state.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = 16'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tmr_load = 1'b1;
                    tmr_val  = CLR_LOAD;
                end
            end
            CLEAR: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = WIN_LOAD;
                end
            end
            RUN: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = SET_LOAD;
                end
            end
            CAPTURE: begin
                if (idx_q != LAST_IDX) begin
                    tmr_load = 1'b1;
                    tmr_val  = CLR_LOAD;
                end
            end
            default: ;
        endcase
    end

    puf_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            chal_q   <= 5'd0;
            resp_q   <= '0;
            tie_q    <= '0;
            ro_en_q  <= 1'b0;
            ro_clr_q <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ro_en_q  <= 1'b0;
                    ro_clr_q <= 1'b0;
                    valid_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    if (start) begin
                        state_q  <= CLEAR;
                        chal_q   <= challenge_base;
                        idx_q    <= '0;
                        resp_q   <= '0;
                        tie_q    <= '0;
                        ro_clr_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (tmr_done) begin
                        state_q  <= RUN;
                        ro_clr_q <= 1'b0;
                        ro_en_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (tmr_done) begin
                        state_q <= SETTLE;
                        ro_en_q <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (tmr_done) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Oscillators have been stopped for SETTLE_CYCLES, so counts are stable here.
                    resp_q[idx_q] <= (count_a > count_b);
                    tie_q[idx_q]  <= (count_a == count_b);
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end else begin
                        state_q  <= CLEAR;
                        idx_q    <= idx_q + 1'b1;
                        chal_q   <= chal_q + 5'd1;
                        ro_clr_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    ro_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign ro_en         = ro_en_q;
    assign ro_clr        = ro_clr_q;
    assign challenge_out = chal_q;
    assign resp          = resp_q;
    assign resp_tie      = tie_q;
    assign resp_valid    = valid_q;
    assign busy          = busy_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed and randomized evaluation of puf_eval_ctrl against a per-challenge
// oscillator-count table model.
module tb_puf_eval_ctrl;
    import puf_pkg::*;

    localparam int W   = 200;
    localparam int S   = 4;
    localparam int N   = 8;
    localparam int LAT = N * (2 + W + S + 1) + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] challenge_base;
    logic [7:0] count_a, count_b;
    logic       ro_en, ro_clr, resp_valid, resp_ready, busy;
    logic [4:0] challenge_out;
    logic [7:0] resp, resp_tie;
    logic [2:0] dbg_state;

    int errors = 0;
    int checks = 0;

    logic [7:0] a_tab [32];
    logic [7:0] b_tab [32];
    logic [4:0] chal_seen [$];

    always #5 clk = ~clk;

    // The oscillator banks respond to whatever challenge the DUT selects.
    assign count_a = a_tab[challenge_out];
    assign count_b = b_tab[challenge_out];

    puf_eval_ctrl #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .NBITS(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .challenge_base (challenge_base),
        .count_a        (count_a),
        .count_b        (count_b),
        .ro_en          (ro_en),
        .ro_clr         (ro_clr),
        .challenge_out  (challenge_out),
        .resp           (resp),
        .resp_tie       (resp_tie),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int chal_of(input logic [4:0] base, input int i);
        return (int'(base) + i) % 32;
    endfunction

    function automatic logic [7:0] model_resp(input logic [4:0] base);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = (int'(a_tab[chal_of(base, i)]) > int'(b_tab[chal_of(base, i)]));
        end
        return r;
    endfunction

    function automatic logic [7:0] model_tie(input logic [4:0] base);
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < N; i++) begin
            t[i] = (int'(a_tab[chal_of(base, i)]) == int'(b_tab[chal_of(base, i)]));
        end
        return t;
    endfunction

    task automatic set_bit(input logic [4:0] base, input int i, input int a, input int b);
        a_tab[chal_of(base, i)] = 8'(a);
        b_tab[chal_of(base, i)] = 8'(b);
    endtask

    task automatic randomize_tables();
        for (int c = 0; c < 32; c++) begin
            a_tab[c] = 8'($urandom_range(0, 255));
            b_tab[c] = ($urandom_range(0, 3) == 0) ? a_tab[c] : 8'($urandom_range(0, 255));
        end
    endtask

    // Issues a start and waits (bounded) for resp_valid, checking timing and results.
    task automatic run_eval(input string tag, input logic [4:0] base);
        int   lat, en_n, clr_n;
        logic prev_en;
        chal_seen.delete();
        challenge_base = base;
        start = 1'b1;
        tick();
        start = 1'b0;
        challenge_base = 5'($urandom);
        lat = 1; en_n = 0; clr_n = 0; prev_en = 1'b0;
        while (!resp_valid && lat < 5000) begin
            if (ro_en && !prev_en) chal_seen.push_back(challenge_out);
            prev_en = ro_en;
            en_n  += int'(ro_en);
            clr_n += int'(ro_clr);
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, LAT);
        chk({tag, " ro_en cycles"}, en_n, N * W);
        chk({tag, " ro_clr cycles"}, clr_n, N * 2);
        chk({tag, " measurements"}, chal_seen.size(), N);
        for (int i = 0; i < chal_seen.size() && i < N; i++) begin
            chk($sformatf("%s challenge[%0d]", tag, i), chal_seen[i], chal_of(base, i));
        end
        chk({tag, " resp"}, resp, model_resp(base));
        chk({tag, " resp_tie"}, resp_tie, model_tie(base));
        chk({tag, " busy in DONE"}, busy, 1);
        chk({tag, " ro_en in DONE"}, ro_en, 0);
    endtask

    // Holds resp_ready low for 'hold' cycles (optionally pulsing start), then accepts.
    task automatic handshake(input string tag, input int hold, input bit pulse);
        logic [7:0] r, t;
        logic [4:0] c;
        r = resp; t = resp_tie; c = challenge_out;
        for (int k = 0; k < hold; k++) begin
            start = pulse && (k % 5 == 2);
            challenge_base = 5'($urandom);
            tick();
            start = 1'b0;
            chk({tag, " hold valid"}, resp_valid, 1);
            chk({tag, " hold resp"}, {resp_tie, resp}, {t, r});
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, " idle after ready"}, dbg_state, IDLE);
        chk({tag, " valid dropped"}, resp_valid, 0);
        chk({tag, " busy dropped"}, busy, 0);
        chk({tag, " resp kept"}, {resp_tie, resp}, {t, r});
        tick();
        chk({tag, " no queued start"}, busy, 0);
        chk({tag, " challenge kept"}, challenge_out, c);
    endtask

    initial begin
        logic [4:0] base;
        int         guard;
        reset = 1'b1; start = 1'b0; resp_ready = 1'b0; challenge_base = 5'd0;
        for (int c = 0; c < 32; c++) begin
            a_tab[c] = 8'd0;
            b_tab[c] = 8'd0;
        end
        tick(); tick(); tick();
        chk("reset state", dbg_state, IDLE);
        chk("reset ro_clr", ro_clr, 1);
        chk("reset ro_en", ro_en, 0);
        chk("reset outputs", {resp_tie, resp, challenge_out, resp_valid, busy}, 0);
        reset = 1'b0;
        tick();
        chk("ro_clr after reset", ro_clr, 0);

        // All bits a>b, challenge stepping 3..10
        for (int i = 0; i < N; i++) set_bit(5'd3, i, 100, 90);
        run_eval("all_ones", 5'd3);
        chk("all_ones const", {resp_tie, resp}, 16'h00FF);
        handshake("all_ones", 0, 1'b0);

        // Challenge wrap 30,31,0..5
        randomize_tables();
        run_eval("wrap", 5'd30);
        handshake("wrap", 0, 1'b0);

        // Alternating measurements
        for (int i = 0; i < N; i++) begin
            if (i % 2 == 0) set_bit(5'd7, i, 50, 60);
            else            set_bit(5'd7, i, 60, 50);
        end
        run_eval("alt", 5'd7);
        chk("alt const", resp, 8'hAA);
        handshake("alt", 0, 1'b0);

        // Ties on bits 0 and 7
        for (int i = 0; i < N; i++) begin
            if (i == 0 || i == 7) set_bit(5'd12, i, 77, 77);
            else                  set_bit(5'd12, i, 200, 10);
        end
        run_eval("ties", 5'd12);
        chk("ties const", {resp_tie, resp}, 16'h817E);
        handshake("ties", 20, 1'b1);

        // resp_ready already high when DONE is entered
        randomize_tables();
        resp_ready = 1'b1;
        run_eval("early_ready", 5'd17);
        tick();
        resp_ready = 1'b0;
        chk("early_ready idle", dbg_state, IDLE);
        chk("early_ready valid", resp_valid, 0);

        // Reset in the middle of RUN for bit 4
        randomize_tables();
        base = 5'd25;
        challenge_base = base;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(ro_en && challenge_out == 5'(chal_of(base, 4))) && guard < 5000) begin
            tick();
            guard++;
        end
        chk("reach bit4 run", guard < 5000, 1);
        repeat (50) tick();
        chk("mid run ro_en", ro_en, 1);
        reset = 1'b1;
        tick();
        chk("abort state", dbg_state, IDLE);
        chk("abort ro_en", ro_en, 0);
        chk("abort ro_clr", ro_clr, 1);
        chk("abort outputs", {resp_tie, resp, challenge_out, resp_valid, busy}, 0);
        reset = 1'b0;
        tick();
        run_eval("restart", 5'd9);
        handshake("restart", 3, 1'b0);

        // Randomized evaluations
        for (int n = 0; n < 3; n++) begin
            randomize_tables();
            run_eval($sformatf("rand%0d", n), 5'($urandom_range(0, 31)));
            handshake($sformatf("rand%0d", n), int'($urandom_range(0, 6)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
